// File: rtl/mux_channel_scanner_pkg.sv
// Shared definitions for the mux channel scanner: state encodings and sizing constants.
package mux_channel_scanner_pkg;

    localparam int unsigned NumCh = 4;
    localparam int unsigned ChW   = 2;
    localparam int unsigned CntW  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mux_next_chan.sv
// Combinational search for the lowest set mask bit strictly above the current channel index.
module mux_next_chan
    import mux_channel_scanner_pkg::*;
(
    input  logic [NumCh-1:0] mask,
    input  logic [ChW-1:0]   cur,
    output logic [ChW-1:0]   nxt,
    output logic             found
);

    // Walk downwards so the lowest qualifying index is the last one written.
    always_comb begin
        found = 1'b0;
        nxt   = cur;
        for (int i = int'(NumCh) - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                found = 1'b1;
                nxt   = ChW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Sequences a 4:1 mux select through the masked channels, lets each settle, and captures
// the returned bit per channel into a scan word handed off with a valid/ready pair.
module mux_channel_scanner
    import mux_channel_scanner_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NumCh-1:0] chan_mask,
    input  logic             y_in,
    output logic [ChW-1:0]   sel,
    output logic             busy,
    output logic [NumCh-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready
);

    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [ChW-1:0]   sel_q, sel_d;
    logic [NumCh-1:0] data_q, data_d;
    logic [NumCh-1:0] mask_q, mask_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [ChW-1:0]   next_idx, above0_idx, first_idx;
    logic             next_found, above0_found, any_set;

    mux_next_chan u_next_chan (
        .mask  (mask_q),
        .cur   (sel_q),
        .nxt   (next_idx),
        .found (next_found)
    );

    // The search is strictly-above, so channel 0 is tested directly for the first pick.
    mux_next_chan u_first_chan (
        .mask  (chan_mask),
        .cur   (ChW'(0)),
        .nxt   (above0_idx),
        .found (above0_found)
    );

    assign first_idx = chan_mask[0] ? ChW'(0) : above0_idx;
    assign any_set   = chan_mask[0] | above0_found;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (start) begin
                    mask_d = chan_mask;
                    data_d = '0;
                    cnt_d  = '0;
                    if (any_set) begin
                        state_d = StScan;
                        sel_d   = first_idx;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StScan: begin
                if (cnt_q == CntLast) begin
                    data_d[sel_q] = y_in;
                    cnt_d         = '0;
                    if (next_found) begin
                        sel_d = next_idx;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (data_ready) begin
                    state_d = StIdle;
                    sel_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
        busy_d  = (state_d != StIdle);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = busy_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Self-checking bench: table-driven scans on an S=2 instance with a result scoreboard,
// plus hand sequences for reset abort and an S=1 instance.
module tb_mux_channel_scanner;

    localparam int S0 = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, ready0, y0, busy0, valid0;
    logic [3:0] mask0, in_pat0, data0;
    logic [1:0] sel0;
    logic       start1, ready1, y1, busy1, valid1;
    logic [3:0] mask1, in_pat1, data1;
    logic [1:0] sel1;

    always #5 clk = ~clk;

    // Model of the downstream 4:1 mux.
    assign y0 = in_pat0[sel0];
    assign y1 = in_pat1[sel1];

    mux_channel_scanner #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .chan_mask  (mask0),
        .y_in       (y0),
        .sel        (sel0),
        .busy       (busy0),
        .data_out   (data0),
        .data_valid (valid0),
        .data_ready (ready0)
    );

    mux_channel_scanner #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .chan_mask  (mask1),
        .y_in       (y1),
        .sel        (sel1),
        .busy       (busy1),
        .data_out   (data1),
        .data_valid (valid1),
        .data_ready (ready1)
    );

    typedef struct {
        logic [3:0] mask;
        logic [3:0] pat;
        int         hold;
        int         restart;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        int         lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_scan(input vec_t v);
        sb_t        e;
        sb_t        got;
        int         edges;
        logic [1:0] sel_hold;
        logic [1:0] trace[$];
        logic [1:0] exp_trace[$];
        in_pat0 = v.pat;
        mask0   = v.mask;
        start0  = 1'b1;
        ready0  = 1'b0;
        e.data  = v.exp_data;
        e.lat   = v.exp_lat;
        sb_q.push_back(e);
        for (int c = 0; c < 4; c++)
            if (v.mask[c])
                for (int k = 0; k < S0; k++) exp_trace.push_back(2'(c));
        @(negedge clk);
        start0 = 1'b0;
        edges  = 0;
        while (!valid0 && edges < 100) begin
            trace.push_back(sel0);
            if (edges == v.restart) begin
                start0 = 1'b1;
                mask0  = ~v.mask;
            end else begin
                start0 = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start0 = 1'b0;
        if (!valid0) check("scan_timeout", valid0, 1);
        check("sel_trace_len", trace.size(), exp_trace.size());
        for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
            check("sel_trace", trace[i], exp_trace[i]);
        check("busy_in_done", busy0, 1);
        got = sb_q.pop_front();
        check("data_out", data0, got.data);
        check("latency", edges, got.lat);
        sel_hold = sel0;
        for (int h = 0; h < v.hold; h++) begin
            start0 = (v.restart >= 0);
            @(negedge clk);
            check("hold_valid", valid0, 1);
            check("hold_data", data0, got.data);
            check("hold_sel", sel0, sel_hold);
        end
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        start0 = 1'b0;
        check("idle_valid", valid0, 0);
        check("idle_busy", busy0, 0);
        check("idle_sel", sel0, 0);
        check("idle_data", data0, got.data);
    endtask

    initial begin
        int edges;
        vecs[0] = '{4'b1111, 4'b1010, 0, -1, 4'b1010, 8};
        vecs[1] = '{4'b0101, 4'b1111, 2, -1, 4'b0101, 4};
        vecs[2] = '{4'b0000, 4'b1111, 5, -1, 4'b0000, 0};
        vecs[3] = '{4'b1000, 4'b1000, 0, -1, 4'b1000, 2};
        vecs[4] = '{4'b0110, 4'b0100, 1, -1, 4'b0100, 4};
        vecs[5] = '{4'b1001, 4'b0001, 0, -1, 4'b0001, 4};
        vecs[6] = '{4'b0010, 4'b1101, 3, -1, 4'b0000, 2};
        vecs[7] = '{4'b0011, 4'b1111, 2, 1, 4'b0011, 4};

        rst_n = 1'b0;
        {start0, ready0, mask0, in_pat0} = '0;
        {start1, ready1, mask1, in_pat1} = '0;
        repeat (2) @(negedge clk);
        check("rst_sel0", sel0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_valid0", valid0, 0);
        check("rst_data0", data0, 0);
        check("rst_sel1", sel1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_valid1", valid1, 0);
        check("rst_data1", data1, 0);

        // Start is presented on the very first edge with reset released.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) run_scan(vecs[i]);

        // Reset while the select sits on channel 2 aborts the scan.
        in_pat0 = 4'b1111;
        mask0   = 4'b1111;
        start0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        edges  = 0;
        while (sel0 != 2'd2 && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        check("abort_reached_sel2", sel0, 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_sel", sel0, 0);
        check("abort_busy", busy0, 0);
        check("abort_valid", valid0, 0);
        check("abort_data", data0, 0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_valid", valid0, 0);
            check("abort_idle", busy0, 0);
        end
        run_scan('{4'b1111, 4'b0110, 0, -1, 4'b0110, 8});

        // Single-cycle settle instance.
        in_pat1 = 4'b1000;
        mask1   = 4'b1000;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s1_sel3", sel1, 3);
        check("s1_busy", busy1, 1);
        check("s1_not_valid", valid1, 0);
        @(negedge clk);
        check("s1_valid", valid1, 1);
        check("s1_data", data1, 4'b1000);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("s1_idle_valid", valid1, 0);
        check("s1_idle_busy", busy1, 0);
        check("s1_idle_sel", sel1, 0);

        in_pat1 = 4'b0010;
        mask1   = 4'b0110;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s1b_sel1", sel1, 1);
        @(negedge clk);
        check("s1b_sel2", sel1, 2);
        check("s1b_not_valid", valid1, 0);
        @(negedge clk);
        check("s1b_valid", valid1, 1);
        check("s1b_data", data1, 4'b0010);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        check("s1b_idle", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1);
    end

endmodule
